ram_blit_engine: RTL

// - Command-driven write master for ram2port-style screen memory: fills or copies a block of words.
// - Drives port 1 (wr/addr1/din) and reads the source through port 2 (addr2/dout2); dout1 is used only
//   by the optional XOR mode. Sits between game logic and the screen memory; the VGA side is untouched.
// - Throughput is one word written per clock; progress is reported via busy/done/err.

---
 rtl/ram_blit_engine.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ram_blit_engine.sv
// Command-driven fill/copy write master for ram2port screen memory, one word per clock.
// Optional BLIT_XOR_EN enables op 10 (destination ^= source, single-cycle read-modify-write).
module ram_blit_engine #(
    parameter int Nloc  = 1200,
    parameter int Dbits = 4,
    parameter int Abits = $clog2(Nloc)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [Abits-1:0] cmd_dst,
    input  logic [Abits-1:0] cmd_src,
    input  logic [Abits:0]   cmd_len,
    input  logic [Dbits-1:0] cmd_data,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mem_wr,
    output logic [Abits-1:0] mem_addr1,
    output logic [Abits-1:0] mem_addr2,
    output logic [Dbits-1:0] mem_din,
    input  logic [Dbits-1:0] mem_dout1,
    input  logic [Dbits-1:0] mem_dout2
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [1:0]       OP_FILL   = 2'b00;
    localparam logic [1:0]       OP_COPY   = 2'b01;
    localparam logic [1:0]       OP_XOR    = 2'b10;
    localparam logic [Abits:0]   LEN_MAX   = (Abits+1)'(Nloc);
    localparam logic [Abits-1:0] ADDR_LAST = Abits'(Nloc - 1);

    state_t           state_q;
    logic [1:0]       op_q;
    logic [Dbits-1:0] fill_q;
    logic [Abits:0]   rem_q;
    logic [Abits-1:0] addr1_q, addr2_q;
    logic [Abits-1:0] addr1_d, addr2_d;
    logic [Dbits-1:0] din_q;
    logic [Dbits-1:0] wdata;
    logic             wr_q, ready_q, busy_q, done_q, err_q;
    logic             op_legal, cmd_legal;

    // Non-power-of-two memory: wrap explicitly at the last location.
    function automatic logic [Abits-1:0] wrap_inc(input logic [Abits-1:0] a);
        return (a == ADDR_LAST) ? '0 : a + Abits'(1);
    endfunction

    always_comb begin
        addr1_d  = wrap_inc(addr1_q);
        addr2_d  = wrap_inc(addr2_q);
        op_legal = (cmd_op == OP_FILL) || (cmd_op == OP_COPY);
`ifdef BLIT_XOR_EN
        op_legal = op_legal || (cmd_op == OP_XOR);
`endif
        cmd_legal = op_legal && (cmd_len != '0) && (cmd_len <= LEN_MAX);
    end

    // Copy data comes straight from the async read port, so write data is combinational.
    always_comb begin
        wdata = fill_q;
        case (op_q)
            OP_COPY: wdata = mem_dout2;
`ifdef BLIT_XOR_EN
            OP_XOR:  wdata = mem_dout1 ^ mem_dout2;
`endif
            default: wdata = fill_q;
        endcase
    end

`ifndef BLIT_XOR_EN
    logic unused_dout1;
    assign unused_dout1 = ^mem_dout1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_FILL;
            fill_q  <= '0;
            rem_q   <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
            din_q   <= '0;
            wr_q    <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_legal) begin
                            state_q <= S_RUN;
                            op_q    <= cmd_op;
                            fill_q  <= cmd_data;
                            rem_q   <= cmd_len;
                            addr1_q <= cmd_dst;
                            addr2_q <= cmd_src;
                            wr_q    <= 1'b1;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    din_q <= wdata;
                    if (abort) begin
                        state_q <= S_IDLE;
                        wr_q    <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (rem_q == (Abits+1)'(1)) begin
                        state_q <= S_DONE;
                        wr_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        rem_q   <= rem_q - (Abits+1)'(1);
                        addr1_q <= addr1_d;
                        addr2_q <= addr2_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    wr_q    <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // abort must suppress the write in the very cycle it is raised.
    assign mem_wr    = wr_q & ~abort;
    assign mem_addr1 = addr1_q;
    assign mem_addr2 = addr2_q;
    assign mem_din   = (state_q == S_RUN) ? wdata : din_q;
    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
